// File: rtl/switch_entry_if.sv
// Operand offer channel from the switch entry block to the processor.
// valid/ready: data_out is held stable while data_valid=1; the transfer completes on the rising edge where data_valid and data_ready are both 1.
interface switch_entry_if;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/switch_entry.sv
// Debounces three active-low keys and builds a decimal operand from sw_digit.
// The operand is offered to the processor on the valid/ready channel.
module switch_entry #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enter_n,
    input  logic           commit_n,
    input  logic           clear_n,
    input  logic [3:0]     sw_digit,
    output logic [15:0]    value,
    output logic [2:0]     digit_count,
    output logic           overflow,
    output logic           state_dbg,
    switch_entry_if.master bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic {ENTRY, OFFER} state_t;

    state_t        state, state_n;
    logic [2:0]    raw, sync1, sync2, deb, deb_d, press;
    logic [CW-1:0] cnt [3];
    logic [15:0]   value_n, data_q, data_n;
    logic [2:0]    count_n;
    logic          ovf_n, valid_q, valid_n;
    logic [19:0]   acc;
    logic          ev_enter, ev_commit, ev_clear;

    assign raw = {clear_n, commit_n, enter_n};

    // The counter holds the run length minus one, so the level flips on the
    // DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
            deb   <= 3'b111;
            deb_d <= 3'b111;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[k] <= sync2[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    assign press     = deb_d & ~deb;
    assign ev_enter  = press[0];
    assign ev_commit = press[1];
    assign ev_clear  = press[2];

    always_comb begin
        state_n = state;
        value_n = value;
        count_n = digit_count;
        ovf_n   = overflow;
        data_n  = data_q;
        valid_n = valid_q;
        acc     = 20'(value) * 20'd10 + 20'(sw_digit);
        case (state)
            ENTRY: begin
                // Only the highest-priority event of a cycle is acted on.
                if (ev_clear) begin
                    value_n = '0;
                    count_n = '0;
                    ovf_n   = 1'b0;
                end else if (ev_commit) begin
                    if (digit_count != 3'd0) begin
                        data_n  = value;
                        valid_n = 1'b1;
                        state_n = OFFER;
                    end
                end else if (ev_enter && sw_digit <= 4'd9 && digit_count < 3'd5) begin
                    if (acc <= 20'd65535) begin
                        value_n = acc[15:0];
                        count_n = digit_count + 3'd1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
            OFFER: begin
                if (bus.data_ready) begin
                    valid_n = 1'b0;
                    value_n = '0;
                    count_n = '0;
                    ovf_n   = 1'b0;
                    state_n = ENTRY;
                end
            end
            default: state_n = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ENTRY;
            value       <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state       <= state_n;
            value       <= value_n;
            digit_count <= count_n;
            overflow    <= ovf_n;
            data_q      <= data_n;
            valid_q     <= valid_n;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign state_dbg      = (state == OFFER);
endmodule

// File: doc/switch_entry.md
# switch_entry

Board-side input block that turns raw push-button and switch activity into clean numeric operands for the processor. It is the input-direction counterpart to the HEX display path. It debounces three active-low keys and accumulates decimal digits from a 4-bit switch field into a 16-bit binary value. It then offers the committed value to the processor over a valid/ready handshake.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable cycles of a synchronized key level required before the debounced level changes (≥2).
- Clock  in  1  system clock; all state updates on rising edge.
- Resetn  in  1  asynchronous active-low reset.
- enter_n  in  1  raw key, active-low: append digit.
- commit_n  in  1  raw key, active-low: offer accumulated value.
- clear_n  in  1  raw key, active-low: discard entry.
- sw_digit  in  4  digit to append; values 10–15 are invalid.
- data_ready  in  1  processor accepts data_out this cycle.
- value  out  16  current accumulator, for display.
- digit_count  out  3  digits accepted so far (0–5).
- overflow  out  1  sticky: a digit was rejected for exceeding 65535.
- data_out  out  16  offered operand.
- data_valid  out  1  data_out is valid.
- Reset values: value=0, digit_count=0, overflow=0, data_out=0, data_valid=0, state=ENTRY, all debounced levels=1 (released), debounce counters=0.

## Operation
- Per key pipeline: 2-flop synchronizer → debounce counter → edge detector.
  - The counter resets whenever the synchronized level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized level and the counter clears.
  - A press event is a single-cycle pulse on the debounced 1→0 transition. Releases generate no event.
- sw_digit is sampled in the cycle of the enter event; no synchronizer is needed, since the switches are static by user contract.
- State ENTRY:
  - Enter event with sw_digit ≤ 9 and digit_count < 5: compute value*10 + sw_digit at 20 bits.
    - If the result is ≤ 65535: value ← result, digit_count += 1.
    - Otherwise value and digit_count are unchanged and overflow ← 1.
  - Enter event with sw_digit > 9, or with digit_count = 5: ignored; overflow is unchanged.
  - Commit event with digit_count > 0: data_out ← value, data_valid ← 1, state → OFFER. Commit with digit_count = 0 is ignored.
  - Clear event: value ← 0, digit_count ← 0, overflow ← 0.
  - Simultaneous events in the same cycle: priority is clear > commit > enter. Lower-priority events in that cycle are dropped.
- State OFFER:
  - data_out and data_valid are held stable until data_ready = 1 is sampled.
  - On that edge: data_valid ← 0, value ← 0, digit_count ← 0, overflow ← 0, state → ENTRY.
  - Enter, commit and clear events are ignored while in OFFER, including any event in the acceptance cycle.
- Resetn low at any time, including mid-debounce or in OFFER, immediately forces all reset values. The offer is withdrawn without handshake.

## Timing
- A key held stable low starting at cycle t:
  - synchronized level low at t+2;
  - debounced level low at t+2+DEBOUNCE_CYCLES;
  - event pulse high during that cycle;
  - value, digit_count or data_valid update at t+3+DEBOUNCE_CYCLES.
- Bounce shorter than DEBOUNCE_CYCLES produces no event. Each stable press produces exactly one event, however long it is held.
- Handshake: transfer completes on the rising edge where data_valid = 1 and data_ready = 1. data_ready while data_valid = 0 has no effect.
- Minimum gap between successive offers: one full key debounce, since a new commit event is required.

## Test plan
- Reset, then DEBOUNCE_CYCLES=4:
  - Press enter_n with sw_digit=7, then 3 → value=73, digit_count=2.
  - Each update appears exactly 7 cycles after the stable key low.
- Bounce: toggle enter_n low/high every 2 cycles for 20 cycles, then release → no event, value unchanged.
  - Repeat with enter_n held low for 100 cycles → exactly one event.
- Overflow: enter 6,5,5,3,5 → value=65535.
  - Clear, then enter 6,5,5,3,6 → value=6553, overflow=1, digit_count=4.
  - Enter sw_digit=12 → ignored.
- Handshake: enter 4,2; commit with data_ready=0 → data_valid=1, data_out=42.
  - Press enter_n during the offer → value stays 42.
  - Assert data_ready for 1 cycle → data_valid=0 and value=0 on the next edge.
- Priority and edge cases:
  - Commit and clear events in the same cycle → cleared, no offer.
  - Commit with digit_count=0 → data_valid stays 0.
- Resetn pulsed low while in OFFER with data_valid=1 → data_valid=0, value=0, state ENTRY immediately, without waiting for a clock edge.
